// File: rtl/demux4_pkg.sv
// demux4 shared types and sizing.
// Lane index and bit counter widths follow from four 8-bit lanes.
package demux4_pkg;

  localparam int LANES = 4;
  localparam int WIDTH = 8;

  typedef logic [1:0] lane_t;
  typedef logic [2:0] cnt_t;

endpackage

// File: rtl/demux4_deser_lane.sv
// One lane: MSB-first shift register, bit counter,
// and a single-word holding register with pending flag.
module lane_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_shift,
  input  logic             i_din,
  input  logic             i_drain,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_word,
  output logic             o_pend,
  output logic             o_ovr
);
  import demux4_pkg::*;

  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_hold;
  cnt_t             r_cnt;
  logic             r_pend;

  logic [WIDTH-1:0] w_next;
  logic             w_shift;
  logic             w_done;

  assign w_shift = i_shift && !i_flush;
  assign w_next  = {r_sh[WIDTH-2:0], i_din};
  assign w_done  = w_shift &&
                   (r_cnt == cnt_t'(WIDTH-1));

  // A drain on the completing edge frees the slot.
  assign o_ovr  = w_done && r_pend && !i_drain;
  assign o_word = r_hold;
  assign o_pend = r_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_hold <= '0;
      r_pend <= 1'b0;
    end else begin
      if (i_flush) begin
        r_sh  <= '0;
        r_cnt <= '0;
      end else if (w_shift) begin
        r_sh  <= w_next;
        r_cnt <= r_cnt + cnt_t'(1);
      end
      if (w_done && !o_ovr) begin
        r_hold <= w_next;
        r_pend <= 1'b1;
      end else if (i_drain) begin
        r_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/demux4_deser.sv
// 4-lane serial demux/deserializer with round-robin
// drain into one registered valid/ready byte port.
module demux4_deser #(
  parameter int LANES = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic [1:0]       sel,
  input  logic             din_valid,
  input  logic             flush,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_lane,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] overrun
);
  import demux4_pkg::*;

  logic [WIDTH-1:0] w_word [LANES];
  logic [LANES-1:0] w_pend;
  logic [LANES-1:0] w_ovr;
  logic [LANES-1:0] w_shift;
  logic [LANES-1:0] w_drain;

  lane_t            w_gnt;
  lane_t            w_idx;
  logic             w_any;
  logic             w_load;

  logic [WIDTH-1:0] r_data;
  lane_t            r_lane;
  logic             r_valid;
  lane_t            r_ptr;
  logic [LANES-1:0] r_ovr;

  assign w_load = !r_valid || out_ready;

  // Scan downward so the lane closest to ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_gnt = r_ptr;
    w_idx = r_ptr;
    for (int k = LANES - 1; k >= 0; k--) begin
      w_idx = r_ptr + lane_t'(k);
      if (w_pend[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_shift[g] = din_valid && !flush &&
                        (sel == lane_t'(g));
    assign w_drain[g] = w_load && w_any &&
                        (w_gnt == lane_t'(g));

    lane_deser #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_shift (w_shift[g]),
      .i_din   (din),
      .i_drain (w_drain[g]),
      .i_flush (flush),
      .o_word  (w_word[g]),
      .o_pend  (w_pend[g]),
      .o_ovr   (w_ovr[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_lane  <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
      r_ovr   <= '0;
    end else begin
      if (w_load) begin
        r_valid <= w_any;
        if (w_any) begin
          r_data <= w_word[w_gnt];
          r_lane <= w_gnt;
          r_ptr  <= w_gnt + lane_t'(1);
        end
      end
      // A new overrun outranks a simultaneous clear.
      r_ovr <= (ovr_clr ? '0 : r_ovr) | w_ovr;
    end
  end

  assign out_data  = r_data;
  assign out_lane  = r_lane;
  assign out_valid = r_valid;
  assign overrun   = r_ovr;

endmodule
